// File: rtl/ysyx_24110006_burst_sram_if.sv
// AXI4 read/write channel bundle between a burst master and the burst SRAM slave.
interface ysyx_24110006_burst_sram_if;
    logic        i_axi_arvalid;
    logic        o_axi_arready;
    logic [31:0] i_axi_araddr;
    logic [3:0]  i_axi_arid;
    logic [7:0]  i_axi_arlen;
    logic [2:0]  i_axi_arsize;
    logic [1:0]  i_axi_arburst;

    logic        o_axi_rvalid;
    logic        i_axi_rready;
    logic [31:0] o_axi_rdata;
    logic [1:0]  o_axi_rresp;
    logic        o_axi_rlast;
    logic [3:0]  o_axi_rid;

    logic        i_axi_awvalid;
    logic        o_axi_awready;
    logic [31:0] i_axi_awaddr;
    logic [3:0]  i_axi_awid;
    logic [7:0]  i_axi_awlen;
    logic [2:0]  i_axi_awsize;
    logic [1:0]  i_axi_awburst;

    logic        i_axi_wvalid;
    logic        o_axi_wready;
    logic [31:0] i_axi_wdata;
    logic [3:0]  i_axi_wstrb;
    logic        i_axi_wlast;

    logic        o_axi_bvalid;
    logic        i_axi_bready;
    logic [1:0]  o_axi_bresp;
    logic [3:0]  o_axi_bid;

    modport slave (
        input  i_axi_arvalid, i_axi_araddr, i_axi_arid, i_axi_arlen, i_axi_arsize, i_axi_arburst,
        output o_axi_arready,
        output o_axi_rvalid, o_axi_rdata, o_axi_rresp, o_axi_rlast, o_axi_rid,
        input  i_axi_rready,
        input  i_axi_awvalid, i_axi_awaddr, i_axi_awid, i_axi_awlen, i_axi_awsize, i_axi_awburst,
        output o_axi_awready,
        input  i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_wlast,
        output o_axi_wready,
        output o_axi_bvalid, o_axi_bresp, o_axi_bid,
        input  i_axi_bready
    );

    modport master (
        output i_axi_arvalid, i_axi_araddr, i_axi_arid, i_axi_arlen, i_axi_arsize, i_axi_arburst,
        input  o_axi_arready,
        input  o_axi_rvalid, o_axi_rdata, o_axi_rresp, o_axi_rlast, o_axi_rid,
        output i_axi_rready,
        output i_axi_awvalid, i_axi_awaddr, i_axi_awid, i_axi_awlen, i_axi_awsize, i_axi_awburst,
        input  o_axi_awready,
        output i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_wlast,
        input  o_axi_wready,
        input  o_axi_bvalid, o_axi_bresp, o_axi_bid,
        output i_axi_bready
    );
endinterface

// File: rtl/ysyx_24110006_burst_sram.sv
// Single-outstanding AXI4 burst SRAM: INCR/FIXED bursts, byte strobes, per-beat
// SLVERR/DECERR responses with sticky write error.
module ysyx_24110006_burst_sram #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    ysyx_24110006_burst_sram_if.slave        axi
);
    localparam int unsigned IW    = DEPTH_LOG2;
    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(WORDS) << 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD    = 2'd1;
    localparam logic [1:0] WR    = 2'd2;
    localparam logic [1:0] WRESP = 2'd3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam logic [1:0] FIXED  = 2'b00;

    // Unsupported size/burst beats are SLVERR; otherwise check the SRAM window.
    function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [2:0] s,
                                             input logic [1:0] b);
        logic [1:0] r;
        r = OKAY;
        if (s > 3'd2 || b[1]) r = SLVERR;
        else if (a < BASE || 33'(a - BASE) >= SPAN) r = DECERR;
        return r;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] s,
                                              input logic [1:0] b);
        return (b == FIXED) ? a : a + (32'd1 << s);
    endfunction

    logic [31:0] mem [WORDS];

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d, cnt_q, cnt_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        arready_q, arready_d, awready_q, awready_d;
    logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0] rd_addr_c, rd_word_c;
    logic [2:0]  rd_size_c;
    logic [1:0]  rd_burst_c, rd_resp_c, wr_resp_c;
    logic        last_beat_c, w_end_c, w_mism_c, mem_we_c;

    // The first beat is read straight off the AR channel so it is valid one cycle after accept.
    assign rd_addr_c   = (state_q == IDLE) ? axi.i_axi_araddr  : addr_q;
    assign rd_size_c   = (state_q == IDLE) ? axi.i_axi_arsize  : size_q;
    assign rd_burst_c  = (state_q == IDLE) ? axi.i_axi_arburst : burst_q;
    assign rd_resp_c   = beat_resp(rd_addr_c, rd_size_c, rd_burst_c);
    assign rd_word_c   = (rd_resp_c == OKAY) ? mem[rd_addr_c[IW+1:2]] : 32'd0;
    assign wr_resp_c   = beat_resp(addr_q, size_q, burst_q);
    assign last_beat_c = (cnt_q == len_q);
    assign w_end_c     = last_beat_c | axi.i_axi_wlast;
    assign w_mism_c    = last_beat_c ^ axi.i_axi_wlast;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        arready_d = arready_q;
        awready_d = awready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arready_q && axi.i_axi_arvalid) begin
                    state_d   = RD;
                    addr_d    = axi.i_axi_araddr;
                    id_d      = axi.i_axi_arid;
                    len_d     = axi.i_axi_arlen;
                    size_d    = axi.i_axi_arsize;
                    burst_d   = axi.i_axi_arburst;
                    cnt_d     = 8'd0;
                    arready_d = 1'b0;
                    awready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word_c;
                    rresp_d   = rd_resp_c;
                    rlast_d   = (axi.i_axi_arlen == 8'd0);
                end else if (awready_q && axi.i_axi_awvalid) begin
                    state_d   = WR;
                    addr_d    = axi.i_axi_awaddr;
                    id_d      = axi.i_axi_awid;
                    len_d     = axi.i_axi_awlen;
                    size_d    = axi.i_axi_awsize;
                    burst_d   = axi.i_axi_awburst;
                    cnt_d     = 8'd0;
                    arready_d = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bresp_d   = OKAY;
                end
            end
            RD: begin
                if (rvalid_q) begin
                    if (axi.i_axi_rready) begin
                        rvalid_d = 1'b0;
                        if (rlast_q) begin
                            state_d   = IDLE;
                            rlast_d   = 1'b0;
                            arready_d = 1'b1;
                            awready_d = 1'b1;
                        end else begin
                            addr_d = next_addr(addr_q, size_q, burst_q);
                            cnt_d  = 8'(cnt_q + 8'd1);
                        end
                    end
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = rd_word_c;
                    rresp_d  = rd_resp_c;
                    rlast_d  = last_beat_c;
                end
            end
            WR: begin
                if (wready_q && axi.i_axi_wvalid) begin
                    mem_we_c = (wr_resp_c == OKAY);
                    // First error seen in the burst is the one reported.
                    if (bresp_q == OKAY)
                        bresp_d = (wr_resp_c != OKAY) ? wr_resp_c : (w_mism_c ? SLVERR : OKAY);
                    if (w_end_c) begin
                        state_d  = WRESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                    end else begin
                        addr_d = next_addr(addr_q, size_q, burst_q);
                        cnt_d  = 8'(cnt_q + 8'd1);
                    end
                end
            end
            WRESP: begin
                if (bvalid_q && axi.i_axi_bready) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    awready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            id_q      <= 4'd0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            arready_q <= 1'b1;
            awready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            arready_q <= arready_d;
            awready_q <= awready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Storage is never reset; contents survive an aborted burst.
    always_ff @(posedge i_clock) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++)
                if (axi.i_axi_wstrb[b]) mem[addr_q[IW+1:2]][8*b +: 8] <= axi.i_axi_wdata[8*b +: 8];
        end
    end

    assign axi.o_axi_arready = arready_q;
    // AR wins a same-cycle tie, so AW must not see ready while AR is requesting.
    assign axi.o_axi_awready = awready_q & ~axi.i_axi_arvalid;
    assign axi.o_axi_rvalid  = rvalid_q;
    assign axi.o_axi_rdata   = rdata_q;
    assign axi.o_axi_rresp   = rresp_q;
    assign axi.o_axi_rlast   = rlast_q;
    assign axi.o_axi_rid     = id_q;
    assign axi.o_axi_wready  = wready_q;
    assign axi.o_axi_bvalid  = bvalid_q;
    assign axi.o_axi_bresp   = bresp_q;
    assign axi.o_axi_bid     = id_q;
endmodule

// File: tb/tb_ysyx_24110006_burst_sram.sv
// Scoreboard bench for the burst SRAM: a word-array model predicts every R beat and
// B response; a monitor compares them as the DUT presents them.
module tb_ysyx_24110006_burst_sram;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ysyx_24110006_burst_sram_if axi ();

    ysyx_24110006_burst_sram #(.DEPTH_LOG2(12), .BASE(BASE)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .axi     (axi)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] mdl [WORDS];
    int          tests;
    int          fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [2:0] s,
                                              input logic [1:0] b);
        if (s > 3'd2 || b == 2'b10 || b == 2'b11) return 2'b10;
        if (64'(a) < 64'(BASE) || 64'(a) >= 64'(BASE) + 64'(4 * WORDS)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                              input logic [2:0] s, input logic [1:0] b);
        return (b == 2'b00) ? a : a + (32'(k) << s);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] s, input logic [1:0] b);
        for (int k = 0; k <= int'(len); k++) begin
            rexp_t    e;
            logic [31:0] ba;
            ba     = beat_addr(a, k, s, b);
            e.resp = model_resp(ba, s, b);
            e.data = (e.resp == 2'b00) ? mdl[widx(ba)] : 32'd0;
            e.last = (k == int'(len));
            e.id   = id;
            rq.push_back(e);
        end
    endtask

    task automatic ar_handshake(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                                input logic [2:0] s, input logic [1:0] b);
        bit hs;
        axi.i_axi_araddr  = a;
        axi.i_axi_arid    = id;
        axi.i_axi_arlen   = len;
        axi.i_axi_arsize  = s;
        axi.i_axi_arburst = b;
        axi.i_axi_arvalid = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            hs = axi.o_axi_arready;
            tick();
        end
        if (!hs) chk("ar_timeout", 32'd0, 32'd1);
        axi.i_axi_arvalid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && (rq.size() != 0 || bq.size() != 0); c++) @(negedge clk);
        if (rq.size() != 0 || bq.size() != 0) begin
            chk("drain_timeout", 32'(rq.size() + bq.size()), 32'd0);
            rq.delete();
            bq.delete();
        end
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] s, input logic [1:0] b);
        push_read(a, id, len, s, b);
        ar_handshake(a, id, len, s, b);
        drain();
    endtask

    // early: -1 wlast on the final beat, -2 never assert wlast, k>=0 wlast on beat k.
    task automatic wr_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] s, input logic [1:0] b, input int early,
                            input bit rnd_data, input logic [31:0] fdata,
                            input bit rnd_strb, input logic [3:0] fstrb);
        logic [31:0] da [256];
        logic [3:0]  sa [256];
        logic        la [256];
        logic [1:0]  sticky;
        int          nb;
        bit          hs;
        bexp_t       be;
        nb     = (early >= 0) ? early + 1 : int'(len) + 1;
        sticky = 2'b00;
        for (int k = 0; k < nb; k++) begin
            logic [31:0] ba;
            logic [1:0]  r;
            logic        mism;
            da[k] = rnd_data ? $urandom : fdata;
            sa[k] = rnd_strb ? 4'($urandom) : fstrb;
            la[k] = (early == -2) ? 1'b0 : (early >= 0) ? (k == early) : (k == int'(len));
            ba    = beat_addr(a, k, s, b);
            r     = model_resp(ba, s, b);
            if (r == 2'b00)
                for (int y = 0; y < 4; y++)
                    if (sa[k][y]) mdl[widx(ba)][8*y +: 8] = da[k][8*y +: 8];
            mism = la[k] != (k == int'(len));
            if (sticky == 2'b00) sticky = (r != 2'b00) ? r : (mism ? 2'b10 : 2'b00);
        end
        be.resp = sticky;
        be.id   = id;
        bq.push_back(be);

        axi.i_axi_awaddr  = a;
        axi.i_axi_awid    = id;
        axi.i_axi_awlen   = len;
        axi.i_axi_awsize  = s;
        axi.i_axi_awburst = b;
        axi.i_axi_awvalid = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 3000 && !hs; c++) begin
            @(negedge clk);
            hs = axi.o_axi_awready;
            tick();
        end
        if (!hs) chk("aw_timeout", 32'd0, 32'd1);
        axi.i_axi_awvalid = 1'b0;

        for (int k = 0; k < nb; k++) begin
            if ($urandom_range(0, 3) == 0) tick();
            axi.i_axi_wdata  = da[k];
            axi.i_axi_wstrb  = sa[k];
            axi.i_axi_wlast  = la[k];
            axi.i_axi_wvalid = 1'b1;
            hs = 1'b0;
            for (int c = 0; c < 200 && !hs; c++) begin
                @(negedge clk);
                hs = axi.o_axi_wready;
                tick();
            end
            if (!hs) chk("w_timeout", 32'(k), 32'hFFFF_FFFF);
            axi.i_axi_wvalid = 1'b0;
            axi.i_axi_wlast  = 1'b0;
        end
        drain();
    endtask

    // Response-side back-pressure.
    initial begin
        axi.i_axi_rready = 1'b0;
        axi.i_axi_bready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            axi.i_axi_rready = ($urandom_range(0, 99) < 60);
            axi.i_axi_bready = ($urandom_range(0, 99) < 50);
        end
    end

    // Monitor: checks R/B outputs against the queues, stall stability and the post-beat bubble.
    initial begin
        bit          held;
        bit          gap;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        rexp_t       e;
        bexp_t       be;
        held = 1'b0;
        gap  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                gap  = 1'b0;
            end else begin
                if (gap) begin
                    chk("r_bubble", 32'(axi.o_axi_rvalid), 32'd0);
                    gap = 1'b0;
                end
                if (axi.o_axi_rvalid) begin
                    if (held) begin
                        chk("r_stall_data", axi.o_axi_rdata, hd);
                        chk("r_stall_resp", 32'(axi.o_axi_rresp), 32'(hr));
                        chk("r_stall_last", 32'(axi.o_axi_rlast), 32'(hl));
                    end
                    if (axi.i_axi_rready) begin
                        held = 1'b0;
                        if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
                        else begin
                            e = rq.pop_front();
                            chk("rdata", axi.o_axi_rdata, e.data);
                            chk("rresp", 32'(axi.o_axi_rresp), 32'(e.resp));
                            chk("rlast", 32'(axi.o_axi_rlast), 32'(e.last));
                            chk("rid", 32'(axi.o_axi_rid), 32'(e.id));
                            gap = !e.last;
                        end
                    end else begin
                        held = 1'b1;
                        hd   = axi.o_axi_rdata;
                        hr   = axi.o_axi_rresp;
                        hl   = axi.o_axi_rlast;
                    end
                end else held = 1'b0;
                if (axi.o_axi_bvalid && axi.i_axi_bready) begin
                    if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
                    else begin
                        be = bq.pop_front();
                        chk("bresp", 32'(axi.o_axi_bresp), 32'(be.resp));
                        chk("bid", 32'(axi.o_axi_bid), 32'(be.id));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < WORDS; i++) mdl[i] = 32'd0;
        axi.i_axi_arvalid = 1'b0; axi.i_axi_araddr = 32'd0; axi.i_axi_arid = 4'd0;
        axi.i_axi_arlen = 8'd0; axi.i_axi_arsize = 3'd0; axi.i_axi_arburst = 2'd0;
        axi.i_axi_awvalid = 1'b0; axi.i_axi_awaddr = 32'd0; axi.i_axi_awid = 4'd0;
        axi.i_axi_awlen = 8'd0; axi.i_axi_awsize = 3'd0; axi.i_axi_awburst = 2'd0;
        axi.i_axi_wvalid = 1'b0; axi.i_axi_wdata = 32'd0; axi.i_axi_wstrb = 4'd0;
        axi.i_axi_wlast = 1'b0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(axi.o_axi_arready), 32'd1);
        chk("rst_awready", 32'(axi.o_axi_awready), 32'd1);
        chk("rst_rvalid", 32'(axi.o_axi_rvalid), 32'd0);
        chk("rst_wready", 32'(axi.o_axi_wready), 32'd0);
        chk("rst_bvalid", 32'(axi.o_axi_bvalid), 32'd0);
        chk("rst_rlast", 32'(axi.o_axi_rlast), 32'd0);
        chk("rst_rresp", 32'(axi.o_axi_rresp), 32'd0);
        chk("rst_bresp", 32'(axi.o_axi_bresp), 32'd0);
        chk("rst_rid", 32'(axi.o_axi_rid), 32'd0);
        chk("rst_bid", 32'(axi.o_axi_bid), 32'd0);
        chk("rst_rdata", axi.o_axi_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fill the first 256 words so every later read has a known value.
        wr_burst(BASE, 4'd1, 8'd255, 3'd2, 2'b01, -1, 1'b1, 32'd0, 1'b0, 4'hF);

        // W beats before any AW are ignored.
        axi.i_axi_wvalid = 1'b1;
        axi.i_axi_wdata  = 32'h5555_5555;
        axi.i_axi_wstrb  = 4'hF;
        @(negedge clk);
        chk("wready_idle", 32'(axi.o_axi_wready), 32'd0);
        tick();
        axi.i_axi_wvalid = 1'b0;

        // Single write then read.
        wr_burst(BASE + 32'h10, 4'd2, 8'd0, 3'd2, 2'b01, -1, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'hF);
        do_read(BASE + 32'h10, 4'd3, 8'd0, 3'd2, 2'b01);

        // Byte strobes.
        wr_burst(BASE + 32'h20, 4'd4, 8'd0, 3'd2, 2'b01, -1, 1'b0, 32'h1122_3344, 1'b0, 4'hF);
        wr_burst(BASE + 32'h20, 4'd4, 8'd0, 3'd2, 2'b01, -1, 1'b0, 32'h0000_AA00, 1'b0, 4'h2);
        do_read(BASE + 32'h20, 4'd5, 8'd0, 3'd2, 2'b01);

        // INCR burst under random rready.
        do_read(BASE, 4'd6, 8'd3, 3'd2, 2'b01);

        // Out of range, then confirm the aliased word 0 is untouched.
        do_read(32'h8001_0000, 4'd7, 8'd0, 3'd2, 2'b01);
        wr_burst(32'h8001_0000, 4'd7, 8'd0, 3'd2, 2'b01, -1, 1'b0, 32'hCAFE_F00D, 1'b0, 4'hF);
        do_read(BASE, 4'd8, 8'd0, 3'd2, 2'b01);

        // Address wrap past 0xFFFF_FFFF, unsupported burst/size.
        do_read(32'hFFFF_FFFC, 4'd9, 8'd1, 3'd2, 2'b01);
        do_read(BASE + 32'h100, 4'd10, 8'd2, 3'd2, 2'b10);
        wr_burst(BASE + 32'h100, 4'd10, 8'd1, 3'd3, 2'b01, -1, 1'b1, 32'd0, 1'b0, 4'hF);
        do_read(BASE + 32'h100, 4'd11, 8'd1, 3'd2, 2'b00);

        // Simultaneous AR and AW: read first, then a write ending early with wlast.
        push_read(BASE + 32'h30, 4'd12, 8'd1, 3'd2, 2'b01);
        axi.i_axi_awaddr = BASE + 32'h40; axi.i_axi_awid = 4'd13; axi.i_axi_awlen = 8'd3;
        axi.i_axi_awsize = 3'd2; axi.i_axi_awburst = 2'b01; axi.i_axi_awvalid = 1'b1;
        axi.i_axi_araddr = BASE + 32'h30; axi.i_axi_arid = 4'd12; axi.i_axi_arlen = 8'd1;
        axi.i_axi_arsize = 3'd2; axi.i_axi_arburst = 2'b01; axi.i_axi_arvalid = 1'b1;
        @(negedge clk);
        chk("prio_arready", 32'(axi.o_axi_arready), 32'd1);
        chk("prio_awready", 32'(axi.o_axi_awready), 32'd0);
        tick();
        axi.i_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("aw_pending", 32'(axi.o_axi_awready), 32'd0);
        drain();
        wr_burst(BASE + 32'h40, 4'd13, 8'd3, 3'd2, 2'b01, 1, 1'b1, 32'd0, 1'b0, 4'hF);
        do_read(BASE + 32'h40, 4'd14, 8'd3, 3'd2, 2'b01);

        // Final beat by counter with wlast never asserted.
        wr_burst(BASE + 32'h80, 4'd15, 8'd1, 3'd2, 2'b01, -2, 1'b1, 32'd0, 1'b0, 4'hF);

        // Random traffic inside the filled region.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [7:0]  len;
            logic [2:0]  s;
            logic [1:0]  b;
            logic [3:0]  id;
            a   = BASE + 32'($urandom_range(0, 240)) * 32'd4;
            len = 8'($urandom_range(0, 7));
            s   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
            b   = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            id  = 4'($urandom);
            if ($urandom_range(0, 1) == 0) do_read(a, id, len, s, b);
            else wr_burst(a, id, len, s, b, -1, 1'b1, 32'd0, 1'b1, 4'h0);
        end

        // Reset during beat 2 of a len7 read.
        push_read(BASE, 4'd3, 8'd7, 3'd2, 2'b01);
        ar_handshake(BASE, 4'd3, 8'd7, 3'd2, 2'b01);
        for (int c = 0; c < 200 && rq.size() > 7; c++) @(negedge clk);
        for (int c = 0; c < 200 && !axi.o_axi_rvalid; c++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(axi.o_axi_rvalid), 32'd0);
        chk("midrst_arready", 32'(axi.o_axi_arready), 32'd1);
        rq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(axi.o_axi_arready), 32'd1);
        chk("post_rst_rvalid", 32'(axi.o_axi_rvalid), 32'd0);
        tick();
        do_read(BASE + 32'h8, 4'd6, 8'd2, 3'd2, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ysyx_24110006_burst_sram.md
YSYX_24110006_BURST_SRAM -- requirements
Module: ysyx_24110006_BURST_SRAM

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning storage of 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, meaning the byte address of word 0.
REQ-003 SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have AR ports: i_axi_arvalid (in, 1); o_axi_arready (out, 1); i_axi_araddr (in, 32); i_axi_arid (in, 4); i_axi_arlen (in, 8); i_axi_arsize (in, 3); i_axi_arburst (in, 2).
REQ-006 SHALL have R ports: o_axi_rvalid (out, 1); i_axi_rready (in, 1); o_axi_rdata (out, 32); o_axi_rresp (out, 2); o_axi_rlast (out, 1); o_axi_rid (out, 4).
REQ-007 SHALL have AW ports: i_axi_awvalid (in, 1); o_axi_awready (out, 1); i_axi_awaddr (in, 32); i_axi_awid (in, 4); i_axi_awlen (in, 8); i_axi_awsize (in, 3); i_axi_awburst (in, 2).
REQ-008 SHALL have W ports: i_axi_wvalid (in, 1); o_axi_wready (out, 1); i_axi_wdata (in, 32); i_axi_wstrb (in, 4); i_axi_wlast (in, 1).
REQ-009 SHALL have B ports: o_axi_bvalid (out, 1); i_axi_bready (in, 1); o_axi_bresp (out, 2); o_axi_bid (out, 4).

Function
REQ-010 SHALL use FSM states IDLE, RD, WR, WRESP, with one transaction outstanding at a time.
REQ-011 SHALL assert o_axi_arready and o_axi_awready only in IDLE.
REQ-012 SHALL give AR priority when arvalid and awvalid are both high in IDLE: AR is accepted, AW stays pending with awready low.
REQ-013 SHALL, on AR accept, latch addr/id/len/size/burst, zero the beat counter, and enter RD.
REQ-014 SHALL, in RD, present a beat with rvalid high starting the cycle after AR accept; rdata = mem[addr[DEPTH_LOG2+1:2]]; rid = latched id.
REQ-015 SHALL hold rdata/rresp/rlast stable while rvalid=1 and rready=0.
REQ-016 SHALL, on R handshake, advance the beat: INCR adds (1<<size) to the address, FIXED keeps it; the next beat is valid the following cycle (1 beat per 2 cycles minimum).
REQ-017 SHALL assert rlast when the beat counter equals the latched len; the rlast handshake returns the FSM to IDLE.
REQ-018 SHALL, on AW accept, latch fields and enter WR with wready=1 the next cycle.
REQ-019 SHALL, on each W handshake, write the bytes of mem[word] selected by wstrb (bit n -> byte n) and advance the address as in REQ-016.
REQ-020 SHALL treat a W handshake with counter==len as the final beat regardless of wlast and then enter WRESP; wlast=1 with counter<len also ends the burst.
REQ-021 SHALL record a wlast/counter mismatch as SLVERR for the burst's bresp.
REQ-022 SHALL, in WRESP, hold bvalid=1 with bid = latched id until the bready handshake, then return to IDLE.
REQ-023 SHALL set response OKAY=2'b00 by default.
REQ-024 SHALL set SLVERR=2'b10 when size>2 or burst==WRAP (2'b10) or burst==2'b11; such beats still complete, with reads returning 0 and writes suppressed.
REQ-025 SHALL set DECERR=2'b11 when a beat's address falls outside [BASE, BASE+4*2^DEPTH_LOG2); the burst is not aborted, writes are suppressed and rdata=0.
REQ-026 SHALL make an error on any write beat sticky for that burst's bresp.
REQ-027 SHALL keep the address arithmetic 32-bit, with wrap-around past 32'hFFFF_FFFF decoding as out-of-range.
REQ-028 SHALL ignore W beats presented in IDLE (wready=0) until their AW is accepted.

Reset
REQ-029 SHALL, while i_reset=0, force the FSM to IDLE and drive outputs to: arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rresp/bresp=0, rid/bid=0, rdata=0.
REQ-030 SHALL abandon an in-flight burst when reset is asserted mid-operation; beats already written persist, and memory contents are not reset.
REQ-031 SHALL accept no handshake on the first edge after reset deassertion other than from IDLE.

Verification
REQ-032 Single write then read: AW 0x8000_0010 len0 size2 INCR, W 0xDEADBEEF strb 0xF -> bresp 00; AR same address -> rdata 0xDEADBEEF, rlast=1, rresp 00.
REQ-033 INCR burst with back-pressure: AR 0x8000_0000 len3 with rready toggling -> 4 beats of mem[0..3] in order, rlast only on beat 4, data stable while stalled.
REQ-034 Byte strobes: write 0x11223344 then strb 0x2 data 0x0000AA00 -> read returns 0x1122AA44.
REQ-035 Out-of-range: AR 0x8001_0000 (DEPTH_LOG2=12) -> rresp 11, rdata 0; AW to the same address -> bresp 11 and memory unchanged.
REQ-036 Simultaneous AR and AW in IDLE -> the read completes first, then AW is accepted; an early wlast on beat 2 of len3 -> bresp 10.
REQ-037 Reset asserted during beat 2 of a len7 read -> rvalid=0 immediately, IDLE after release, and the next AR is served normally.
